ahb_sram_slave: RTL

Synthesisable AHB-Lite slave with an internal word-organised SRAM, configurable wait states, an error-response address window and byte/halfword/word (and doubleword at 64-bit) write strobes. It replaces the free-running random `i_hready` generator in the `ahb_master` bench. It gives the master a protocol-correct, data-checking target whose stall and error behaviour is deterministic and parameter-controlled.

---
 rtl/ahb_sram_slave.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave backed by a word-wide SRAM with fixed wait states, an
// error-response address window and byte-lane write strobes.
module ahb_sram_slave #(
  parameter int unsigned BUS_WDT  = 32,
  parameter int unsigned DEPTH    = 1024,
  parameter int unsigned WAIT     = 0,
  parameter logic [31:0] ERR_BASE = 32'hFFFF_F000,
  parameter logic [31:0] ERR_SIZE = 32'h0000_1000
) (
  input  logic               i_hclk,
  input  logic               i_hreset_n,
  input  logic               i_hsel,
  input  logic               i_hready,
  input  logic [31:0]        i_haddr,
  input  logic [1:0]         i_htrans,
  input  logic [1:0]         i_hsize,
  input  logic               i_hwrite,
  input  logic [BUS_WDT-1:0] i_hwdata,
  output logic               o_hready,
  output logic [1:0]         o_hresp,
  output logic [BUS_WDT-1:0] o_hrdata
);
  localparam int unsigned BYTES     = BUS_WDT / 8;
  localparam int unsigned BBITS     = $clog2(BYTES);
  localparam int unsigned ABITS     = $clog2(DEPTH);
  localparam logic [2:0]  WAIT_LOAD = (WAIT > 0) ? 3'(WAIT - 1) : 3'd0;
  localparam logic [1:0]  RESP_OKAY = 2'b00;
  localparam logic [1:0]  RESP_ERR  = 2'b01;
  localparam logic [32:0] WIN_LO    = {1'b0, ERR_BASE};
  localparam logic [32:0] WIN_HI    = {1'b0, ERR_BASE} + {1'b0, ERR_SIZE};

  typedef enum logic [2:0] {S_IDLE, S_WAITST, S_DONE, S_ERR1, S_ERR2} state_t;

  state_t             r_state;
  logic [2:0]         r_cnt;
  logic               r_pend;
  logic               r_write;
  logic               r_err;
  logic [ABITS-1:0]   r_idx;
  logic [BYTES-1:0]   r_be;
  logic [BUS_WDT-1:0] r_mem [DEPTH];

  logic               w_capture;
  logic               w_winErr;
  logic               w_sizeErr;
  logic               w_alignErr;
  logic               w_err;
  logic               w_commit;
  logic [3:0]         w_sizeBytes;
  logic [2:0]         w_alignMask;
  logic [ABITS-1:0]   w_idx;
  logic [15:0]        w_beWide;
  logic [BYTES-1:0]   w_be;
  logic [BUS_WDT-1:0] w_mask;
  logic [BUS_WDT-1:0] w_memWord;
  logic [BUS_WDT-1:0] w_pendWord;
  logic [BUS_WDT-1:0] w_fwdWord;
  logic               w_unused;

  // Gating with o_hready keeps a misbehaving HREADYIN from starting a transfer mid-stall.
  assign w_capture   = i_hsel & i_hready & i_htrans[1] & o_hready;
  assign w_sizeBytes = 4'd1 << i_hsize;
  assign w_alignMask = w_sizeBytes[2:0] - 3'd1;
  assign w_winErr    = (ERR_SIZE != 32'd0) && ({1'b0, i_haddr} >= WIN_LO) &&
                       ({1'b0, i_haddr} < WIN_HI);
  assign w_sizeErr   = w_sizeBytes > 4'(BYTES);
  assign w_alignErr  = (i_haddr[2:0] & w_alignMask) != 3'd0;
  assign w_err       = w_winErr | w_sizeErr | w_alignErr;
  assign w_idx       = i_haddr[ABITS+BBITS-1:BBITS];
  assign w_beWide    = ((16'd1 << w_sizeBytes) - 16'd1) << i_haddr[BBITS-1:0];
  assign w_be        = w_beWide[BYTES-1:0];
  assign w_unused    = ^{i_htrans[0], w_beWide[15:BYTES]};

  always_comb begin
    w_mask = '0;
    for (int unsigned b = 0; b < BYTES; b++) w_mask[8*b +: 8] = {8{r_be[b]}};
  end

  assign w_commit   = r_pend & r_write;
  assign w_memWord  = r_mem[w_idx];
  assign w_pendWord = r_mem[r_idx];
  // A read captured while a write to the same word commits sees the merged word.
  assign w_fwdWord  = (w_commit && (r_idx == w_idx)) ?
                      ((w_memWord & ~w_mask) | (i_hwdata & w_mask)) : w_memWord;

  always_ff @(posedge i_hclk) begin
    for (int unsigned b = 0; b < BYTES; b++)
      if (w_commit && r_be[b]) r_mem[r_idx][8*b +: 8] <= i_hwdata[8*b +: 8];
  end

  always_ff @(posedge i_hclk or negedge i_hreset_n) begin
    if (!i_hreset_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_pend   <= 1'b0;
      r_write  <= 1'b0;
      r_err    <= 1'b0;
      r_idx    <= '0;
      r_be     <= '0;
      o_hready <= 1'b1;
      o_hresp  <= RESP_OKAY;
      o_hrdata <= '0;
    end else begin
      r_pend   <= 1'b0;
      o_hrdata <= '0;
      if (w_capture) begin
        r_idx   <= w_idx;
        r_be    <= w_be;
        r_write <= i_hwrite;
        r_err   <= w_err;
      end
      case (r_state)
        S_IDLE, S_DONE, S_ERR2: begin
          if (w_capture && (WAIT > 0)) begin
            r_state  <= S_WAITST;
            r_cnt    <= WAIT_LOAD;
            o_hready <= 1'b0;
            o_hresp  <= RESP_OKAY;
          end else if (w_capture && w_err) begin
            r_state  <= S_ERR1;
            o_hready <= 1'b0;
            o_hresp  <= RESP_ERR;
          end else begin
            r_state  <= S_IDLE;
            o_hready <= 1'b1;
            o_hresp  <= RESP_OKAY;
            if (w_capture) begin
              r_pend <= 1'b1;
              if (!i_hwrite) o_hrdata <= w_fwdWord;
            end
          end
        end
        S_WAITST: begin
          if (r_cnt == 3'd0) begin
            if (r_err) begin
              r_state  <= S_ERR1;
              o_hready <= 1'b0;
              o_hresp  <= RESP_ERR;
            end else begin
              r_state  <= S_DONE;
              o_hready <= 1'b1;
              o_hresp  <= RESP_OKAY;
              r_pend   <= 1'b1;
              if (!r_write) o_hrdata <= w_pendWord;
            end
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        S_ERR1: begin
          r_state  <= S_ERR2;
          o_hready <= 1'b1;
          o_hresp  <= RESP_ERR;
        end
        default: begin
          r_state  <= S_IDLE;
          o_hready <= 1'b1;
          o_hresp  <= RESP_OKAY;
        end
      endcase
    end
  end
endmodule
